// File: rtl/mult_accumulator_if.sv
// Handshake bundle between the multiplier-side producer and mult_accumulator.
// Master drives product beats and result ready; slave returns batch results.
interface mult_accumulator_if #(
    parameter int IN_W  = 48,
    parameter int ACC_W = 56,
    parameter int CNT_W = 8
);
    logic             valid_data_in;
    logic [IN_W-1:0]  in;
    logic [CNT_W-1:0] count_cfg;
    logic             clear;
    logic             ready_in;
    logic [ACC_W-1:0] acc_out;
    logic             valid_data_out;
    logic             overflow;
    logic             drop_err;
    logic             busy;

    modport master (
        output valid_data_in,
        output in,
        output count_cfg,
        output clear,
        output ready_in,
        input  acc_out,
        input  valid_data_out,
        input  overflow,
        input  drop_err,
        input  busy
    );

    modport slave (
        input  valid_data_in,
        input  in,
        input  count_cfg,
        input  clear,
        input  ready_in,
        output acc_out,
        output valid_data_out,
        output overflow,
        output drop_err,
        output busy
    );
endinterface

// File: rtl/mult_accumulator.sv
// Saturating batch accumulator for the Dadda multiplier product stream,
// with a one-deep valid/ready result register and sticky drop flag.
module mult_accumulator #(
    parameter int IN_W  = 48,
    parameter int ACC_W = 56,
    parameter int CNT_W = 8
) (
    input logic               clk,
    input logic               rst,
    mult_accumulator_if.slave bus
);
    typedef enum logic {IDLE, ACCUM} acc_st_e;
    typedef enum logic {EMPTY, FULL} out_st_e;

    acc_st_e          acc_st_q;
    out_st_e          out_st_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] res_q;
    logic [ACC_W:0]   sum;
    logic [CNT_W-1:0] beat_q;
    logic [CNT_W-1:0] beat_d;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] n_eff;
    logic             ovf_q;
    logic             ovf_d;
    logic             rovf_q;
    logic             drop_q;
    logic             busy_q;
    logic             valid_q;
    logic             beat_en;
    logic             last;
    logic             mid;

    // Zero-extended sum with one carry bit; the carry is the saturation flag.
    always_comb begin
        sum     = {1'b0, acc_q} + (ACC_W+1)'(bus.in);
        acc_d   = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        ovf_d   = ovf_q | sum[ACC_W];
        n_eff   = (acc_st_q == IDLE) ? bus.count_cfg : n_q;
        beat_d  = beat_q + CNT_W'(1);
        beat_en = bus.valid_data_in & ~bus.clear;
        // N=0 means 2^CNT_W: the counter wraps to 0 on exactly that beat.
        last    = beat_en & (beat_d == n_eff);
        mid     = beat_en & ~last;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_st_q <= IDLE;
            out_st_q <= EMPTY;
            acc_q    <= '0;
            beat_q   <= '0;
            n_q      <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            res_q    <= '0;
            rovf_q   <= 1'b0;
            valid_q  <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            unique case (1'b1)
                bus.clear, last: begin
                    acc_st_q <= IDLE;
                    acc_q    <= '0;
                    beat_q   <= '0;
                    ovf_q    <= 1'b0;
                    busy_q   <= 1'b0;
                end
                mid: begin
                    acc_st_q <= ACCUM;
                    acc_q    <= acc_d;
                    beat_q   <= beat_d;
                    ovf_q    <= ovf_d;
                    busy_q   <= 1'b1;
                    if (acc_st_q == IDLE) begin
                        n_q <= bus.count_cfg;
                    end
                end
                default: begin
                end
            endcase

            unique case (out_st_q)
                EMPTY: begin
                    if (last) begin
                        out_st_q <= FULL;
                        valid_q  <= 1'b1;
                        res_q    <= acc_d;
                        rovf_q   <= ovf_d;
                    end
                end
                FULL: begin
                    if (last && bus.ready_in) begin
                        res_q  <= acc_d;
                        rovf_q <= ovf_d;
                    end else if (last) begin
                        drop_q <= 1'b1;
                    end else if (bus.ready_in) begin
                        out_st_q <= EMPTY;
                        valid_q  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.acc_out        = res_q;
    assign bus.valid_data_out = valid_q;
    assign bus.overflow       = rovf_q;
    assign bus.drop_err       = drop_q;
    assign bus.busy           = busy_q;
endmodule

// File: doc/mult_accumulator.md
# mult_accumulator

Downstream consumer of the 24x24 Dadda multiplier stage: takes the 48-bit product stream and its `valid_data_out` qualifier, sums a programmable number of consecutive products into a wide accumulator, and presents each batch sum on a valid/ready output. The multiplier has no backpressure, so this block never stalls its input. It buffers one finished result and flags, rather than blocks, when results are lost.

## Interface
Parameters:
- IN_W, 48, product width; matches the multiplier output.
- ACC_W, 56, accumulator/result width; must be >= IN_W.
- CNT_W, 8, width of the batch-length field.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous assert, active-low; clears all state.
- valid_data_in  input  1  product beat valid; driven by the multiplier's valid_data_out.
- in  input  IN_W  unsigned product, qualified by valid_data_in.
- count_cfg  input  CNT_W  batch length N; value 0 means 2^CNT_W.
- clear  input  1  synchronous abort of the batch in progress.
- ready_in  input  1  downstream accepts the result.
- acc_out  output  ACC_W  batch sum; stable while valid_data_out=1.
- valid_data_out  output  1  result held in the output register.
- overflow  output  1  sideband of acc_out; batch sum saturated.
- drop_err  output  1  sticky; a completed result was discarded.
- busy  output  1  batch in progress (beat count != 0).

## Operation
- Accumulate side. States:
  - IDLE: acc=0, beat=0.
  - ACCUM: 0 < beat < N.
- count_cfg is latched as N_lat on the first beat of a batch (valid_data_in=1 while in IDLE). It is ignored mid-batch.
- Each beat: acc <= sat(acc + in) and beat <= beat+1. The `in` value is zero-extended to ACC_W.
- sat: if the unsigned sum exceeds 2^ACC_W-1, hold acc at all-ones and set the batch's ovf bit.
- Last beat (beat == N_lat-1, or N_lat==1 on the first beat):
  - Produce the final sum sat(acc+in) with its ovf bit.
  - Return to IDLE: acc=0, beat=0, ovf=0, all in the same edge.
  - A new first beat on the very next cycle is legal. No beat is ever lost between batches.
- clear=1 resets acc, beat, and ovf to 0 and returns to IDLE. It overrides a coincident valid_data_in, so that beat is discarded. clear does not touch the output register or drop_err.
- Output side. States:
  - EMPTY: valid_data_out=0.
  - FULL: valid_data_out=1.
- On a completed batch:
  - If EMPTY, or FULL with ready_in=1 that cycle: load acc_out/overflow and go to (or stay) FULL.
  - If FULL with ready_in=0: keep the old result, discard the new one, and set drop_err=1.
- FULL with ready_in=1 and no completion: go to EMPTY.
- drop_err is cleared only by rst.

## Timing
- Reset values: acc_out=0, valid_data_out=0, overflow=0, drop_err=0, busy=0, internal acc=0, beat=0.
- Latency: valid_data_out rises on the edge that registers the last beat. The result is visible in the cycle after the last beat is presented.
- Throughput: one beat per cycle sustained. For N=1, one result per cycle when ready_in is held at 1.
- Output is handshaken on clk: a transfer occurs in any cycle with valid_data_out=1 and ready_in=1. acc_out and overflow must not change while valid_data_out=1 && ready_in=0.
- busy is registered. It is 1 from the edge after the first beat of an N>1 batch until the edge that takes the last beat.
- rst asserted mid-batch or with FULL output: everything returns to reset values immediately. A pending result is lost without setting drop_err.
- count_cfg=0: N = 2^CNT_W (256 at default). The beat counter wraps to 0 exactly at completion.

## Test plan
- Basic batch: N=3, products 0x000000000005, 0x000000000007, 0x00000000000A on consecutive cycles, ready_in=1 -> one cycle after the third beat, valid_data_out=1 and acc_out=0x16. overflow=0.
- Back-to-back, N=1: 4 consecutive beats 1,2,3,4 with ready_in=1 -> valid_data_out stays 1 for 4 cycles, acc_out sequence 1,2,3,4, drop_err=0.
- Backpressure and drop: N=1, ready_in=0, beats 0xA then 0xB -> acc_out remains 0xA and drop_err=1. Raising ready_in then gives one transfer of 0xA, then valid_data_out=0.
- Saturation: ACC_W=49, N=3, three beats of 0xFFFFFFFFFFFF -> acc_out=0x1FFFFFFFFFFFF and overflow=1. The next batch (N=1, beat 2) gives acc_out=2 and overflow=0.
- Clear and count wrap: N=4, two beats, then clear together with a beat of 0x100 -> busy=0 and no output. Next, count_cfg=0 with 256 beats of 1 -> exactly one result, acc_out=0x100.
- Async reset mid-batch and with FULL output: rst low between clock edges -> all outputs 0 immediately. A fresh N=2 batch (3, 4) after release gives acc_out=7.
